bf_sram_ctrl: RTL and testbench
===============================

Name: bf_sram_ctrl

Overview:
- Controller for a single 2^ADDR_W x 1 true-dual-port Bloom-filter bit array (8192 x 1 at default).
- Arbitrates insert and query requesters, each carrying two precomputed hash indices, onto ports A and B. Both indices are serviced in one cycle.
- Sequences a full-array clear, automatically after reset and on request.
- Returns tagged query hit/miss responses.

Parameters:
- ADDR_W, 13: bit-array address width; 2^ADDR_W must be even.
- RD_LAT, 2: SRAM read latency in cycles, from address/wren registered at the SRAM to q valid.
- TAG_W, 8: query tag width.

Ports:
- clock  in  1: sole clock.
- reset_n  in  1: asynchronous active-low reset.
- ins_valid  in  1: insert request valid.
- ins_ready  out  1: insert accepted when ins_valid && ins_ready.
- ins_idx0  in  ADDR_W: insert hash index 0.
- ins_idx1  in  ADDR_W: insert hash index 1.
- qry_valid  in  1: query request valid.
- qry_ready  out  1: query accepted when qry_valid && qry_ready.
- qry_idx0  in  ADDR_W: query hash index 0.
- qry_idx1  in  ADDR_W: query hash index 1.
- qry_tag  in  TAG_W: tag echoed on the response.
- clr_req  in  1: single-cycle clear request.
- clr_busy  out  1: clear pending or in progress.
- rsp_valid  out  1: one-cycle response strobe; no backpressure.
- rsp_hit  out  1: both bits set.
- rsp_tag  out  TAG_W: tag of the answered query.
- sram_address_a  out  ADDR_W: SRAM port A address.
- sram_address_b  out  ADDR_W: SRAM port B address.
- sram_data_a  out  1: SRAM port A write data.
- sram_data_b  out  1: SRAM port B write data.
- sram_wren_a  out  1: SRAM port A write enable.
- sram_wren_b  out  1: SRAM port B write enable.
- sram_q_a  in  1: SRAM port A read data.
- sram_q_b  in  1: SRAM port B read data.

Behaviour:
- Reset values:
  - All SRAM-side outputs 0.
  - ins_ready = 0, qry_ready = 0.
  - rsp_valid = 0, rsp_hit = 0, rsp_tag = 0.
  - clr_busy = 1; state = SWEEP, sweep counter = 0. Every reset performs an automatic clear.
- States:
  - RUN: normal operation.
  - DRAIN: clear pending; waits for in-flight queries to complete.
  - SWEEP: writes zeros across the array.
- RUN:
  - At most one request accepted per cycle. ready signals are combinational from state, the other valid, and last_grant.
  - Only one valid: it is granted.
  - Both valid: round-robin; grant the class not granted last. last_grant resets to query, so insert wins the first tie.
  - Accept at cycle t, then SRAM signals are registered and driven at t+1.
  - Insert drives addr_a = idx0, addr_b = idx1, data = 1, wren_a = 1, wren_b = (idx1 != idx0). When the indices are equal, port A writes alone; same-address dual-port writes are forbidden.
  - Query drives the addresses with wren = 0.
  - rsp_valid is asserted at t+2+RD_LAT, with rsp_hit = q_a & q_b and rsp_tag = the accepted tag.
  - Query responses return in acceptance order.
  - The in-flight query tracker is a shift register of depth RD_LAT+1.
- Ordering:
  - An insert accepted at t is visible to any query accepted at t+1 or later, because the write precedes the read at the SRAM.
  - A query accepted before an insert to the same index returns the old value.
- Clear:
  - clr_req in RUN sets clr_busy the next cycle.
  - From that cycle, ins_ready and qry_ready are held at 0, and the state goes to DRAIN.
  - DRAIN exits to SWEEP once no query is in flight; outstanding responses are still delivered.
  - SWEEP: counter i runs 0 .. 2^(ADDR_W-1)-1. Each cycle drives addr_a = 2i, addr_b = 2i+1, data = 0, both wren = 1. Default is 4096 cycles.
  - After the last write, return to RUN; clr_busy deasserts and ready may assert the following cycle.
  - clr_req while clr_busy = 1 is ignored; it neither extends nor restarts the sweep.
  - clr_req in the same cycle as an accepted request: the request completes, and the clear follows.
- Mid-operation reset: all state is abandoned, in-flight responses are dropped (no rsp_valid), and a fresh SWEEP begins.
- The SRAM is never read and written on the same port in the same cycle.

Optional Feature:
- Macro BF_STATS_EN.
- When defined, adds three outputs, each reset to 0 and wrapping at 2^32:
  - stat_ins_cnt [31:0]: +1 per accepted insert.
  - stat_qry_cnt [31:0]: +1 per accepted query.
  - stat_hit_cnt [31:0]: +1 per rsp_valid with rsp_hit = 1.
- Counters are zeroed when a SWEEP starts.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - clr_busy = 1 for the sweep, then 0.
  - ready is low throughout the sweep.
  - Every even address is written on A and every odd address on B, with data 0, 4096 cycles at default.
- Insert (idx 0x0010, 0x1FFF), then query the same pair with tag 0x5A one cycle later: rsp_valid at accept+4 (RD_LAT = 2), rsp_hit = 1, rsp_tag = 0x5A.
- Query (0x0010, 0x0011) after that insert: rsp_hit = 0.
- Insert (0x0ABC, 0x0ABC): only sram_wren_a pulses. A subsequent query of the same pair gives hit = 1.
- ins_valid and qry_valid held high for 6 cycles: grants alternate ins, qry, ins, qry, ins, qry; exactly 3 in-order responses.
- Clear with 2 queries in flight:
  - Both responses are delivered before the first sweep write.
  - A query of an inserted pair after clr_busy falls returns hit = 0.
  - A second clr_req mid-sweep causes no extra sweep cycles.
- reset_n low mid-query: no rsp_valid appears, and a full sweep restarts.
- With BF_STATS_EN defined: after 3 inserts, 2 queries and 1 hit, the counters read 3 / 2 / 1.

Source files
------------

// File: rtl/bf_sram_ctrl.sv
// Bloom-filter bit-array controller: arbitrates inserts/queries onto a true-dual-port 2^ADDR_W x 1 SRAM
// and sequences full-array clears. Define BF_STATS_EN to add insert/query/hit counters.
module bf_sram_ctrl #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [ADDR_W-1:0] ins_idx0,
  input  logic [ADDR_W-1:0] ins_idx1,
  input  logic              qry_valid,
  output logic              qry_ready,
  input  logic [ADDR_W-1:0] qry_idx0,
  input  logic [ADDR_W-1:0] qry_idx1,
  input  logic [TAG_W-1:0]  qry_tag,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [ADDR_W-1:0] sram_address_a,
  output logic [ADDR_W-1:0] sram_address_b,
  output logic              sram_data_a,
  output logic              sram_data_b,
  output logic              sram_wren_a,
  output logic              sram_wren_b,
  input  logic              sram_q_a,
  input  logic              sram_q_b
`ifdef BF_STATS_EN
  ,
  output logic [31:0]       stat_ins_cnt,
  output logic [31:0]       stat_qry_cnt,
  output logic [31:0]       stat_hit_cnt
`endif
);

  localparam int unsigned CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] SWEEP_LAST = '1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  localparam logic GNT_QRY = 1'b0;
  localparam logic GNT_INS = 1'b1;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] sweep_cnt, sweep_nx;
  logic             last_grant, last_grant_nx;
  logic             clr_busy_nx;

  logic [ADDR_W-1:0] addr_a_nx, addr_b_nx;
  logic              data_a_nx, data_b_nx, wren_a_nx, wren_b_nx;

  logic [RD_LAT:0]            trk_vld, trk_vld_nx;
  logic [RD_LAT:0][TAG_W-1:0] trk_tag, trk_tag_nx;
  logic                       rsp_valid_nx, rsp_hit_nx;
  logic [TAG_W-1:0]           rsp_tag_nx;

  logic run, ins_acc, qry_acc;

  // Round-robin grant: on a tie the class not served last wins.
  assign run       = (state == ST_RUN);
  assign ins_ready = run && (!qry_valid || (last_grant == GNT_QRY));
  assign qry_ready = run && (!ins_valid || (last_grant == GNT_INS));
  assign ins_acc   = ins_valid && ins_ready;
  assign qry_acc   = qry_valid && qry_ready;

  // Next state and next SRAM command.
  always_comb begin
    state_nx      = state;
    sweep_nx      = sweep_cnt;
    last_grant_nx = last_grant;
    clr_busy_nx   = clr_busy;
    addr_a_nx     = sram_address_a;
    addr_b_nx     = sram_address_b;
    data_a_nx     = 1'b0;
    data_b_nx     = 1'b0;
    wren_a_nx     = 1'b0;
    wren_b_nx     = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (ins_acc) begin
          addr_a_nx     = ins_idx0;
          addr_b_nx     = ins_idx1;
          data_a_nx     = 1'b1;
          data_b_nx     = 1'b1;
          wren_a_nx     = 1'b1;
          // equal indices: port A writes alone to avoid a same-address dual write
          wren_b_nx     = (ins_idx1 != ins_idx0);
          last_grant_nx = GNT_INS;
        end else if (qry_acc) begin
          addr_a_nx     = qry_idx0;
          addr_b_nx     = qry_idx1;
          last_grant_nx = GNT_QRY;
        end
        if (clr_req) begin
          clr_busy_nx = 1'b1;
          state_nx    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (trk_vld == '0) begin
          state_nx = ST_SWEEP;
          sweep_nx = '0;
        end
      end
      ST_SWEEP: begin
        addr_a_nx = {sweep_cnt, 1'b0};
        addr_b_nx = {sweep_cnt, 1'b1};
        wren_a_nx = 1'b1;
        wren_b_nx = 1'b1;
        if (sweep_cnt == SWEEP_LAST) begin
          state_nx    = ST_RUN;
          clr_busy_nx = 1'b0;
        end else begin
          sweep_nx = sweep_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx    = ST_SWEEP;
        sweep_nx    = '0;
        clr_busy_nx = 1'b1;
      end
    endcase
  end

  // In-flight query tracker; stage RD_LAT lines up with valid SRAM read data.
  always_comb begin
    trk_vld_nx    = '0;
    trk_tag_nx    = '0;
    trk_vld_nx[0] = qry_acc;
    trk_tag_nx[0] = qry_tag;
    for (int unsigned k = 1; k <= RD_LAT; k++) begin
      trk_vld_nx[k] = trk_vld[k-1];
      trk_tag_nx[k] = trk_tag[k-1];
    end
    rsp_valid_nx = trk_vld[RD_LAT];
    rsp_hit_nx   = trk_vld[RD_LAT] & sram_q_a & sram_q_b;
    rsp_tag_nx   = trk_vld[RD_LAT] ? trk_tag[RD_LAT] : rsp_tag;
  end

  // Every reset starts an automatic sweep from address 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_SWEEP;
      sweep_cnt      <= '0;
      last_grant     <= GNT_QRY;
      clr_busy       <= 1'b1;
      sram_address_a <= '0;
      sram_address_b <= '0;
      sram_data_a    <= 1'b0;
      sram_data_b    <= 1'b0;
      sram_wren_a    <= 1'b0;
      sram_wren_b    <= 1'b0;
      trk_vld        <= '0;
      trk_tag        <= '0;
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_tag        <= '0;
    end else begin
      state          <= state_nx;
      sweep_cnt      <= sweep_nx;
      last_grant     <= last_grant_nx;
      clr_busy       <= clr_busy_nx;
      sram_address_a <= addr_a_nx;
      sram_address_b <= addr_b_nx;
      sram_data_a    <= data_a_nx;
      sram_data_b    <= data_b_nx;
      sram_wren_a    <= wren_a_nx;
      sram_wren_b    <= wren_b_nx;
      trk_vld        <= trk_vld_nx;
      trk_tag        <= trk_tag_nx;
      rsp_valid      <= rsp_valid_nx;
      rsp_hit        <= rsp_hit_nx;
      rsp_tag        <= rsp_tag_nx;
    end
  end

`ifdef BF_STATS_EN
  logic sweep_start;
  assign sweep_start = (state == ST_DRAIN) && (state_nx == ST_SWEEP);

  // Activity counters, cleared whenever a sweep begins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_ins_cnt <= '0;
      stat_qry_cnt <= '0;
      stat_hit_cnt <= '0;
    end else if (sweep_start) begin
      stat_ins_cnt <= '0;
      stat_qry_cnt <= '0;
      stat_hit_cnt <= '0;
    end else begin
      if (ins_acc)              stat_ins_cnt <= stat_ins_cnt + 32'd1;
      if (qry_acc)              stat_qry_cnt <= stat_qry_cnt + 32'd1;
      if (rsp_valid && rsp_hit) stat_hit_cnt <= stat_hit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bf_sram_ctrl.sv
// Bench for bf_sram_ctrl: SRAM model plus a set-of-bits reference with an expected-response queue.
module tb_bf_sram_ctrl;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned TAG_W     = 8;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned SWEEP_LEN = DEPTH / 2;
  localparam int          RSP_LAT   = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              ins_valid = 1'b0, ins_ready;
  logic [ADDR_W-1:0] ins_idx0 = '0, ins_idx1 = '0;
  logic              qry_valid = 1'b0, qry_ready;
  logic [ADDR_W-1:0] qry_idx0 = '0, qry_idx1 = '0;
  logic [TAG_W-1:0]  qry_tag = '0;
  logic              clr_req = 1'b0, clr_busy;
  logic              rsp_valid, rsp_hit;
  logic [TAG_W-1:0]  rsp_tag;
  logic [ADDR_W-1:0] sram_address_a, sram_address_b;
  logic              sram_data_a, sram_data_b, sram_wren_a, sram_wren_b;
  logic              sram_q_a, sram_q_b;
`ifdef BF_STATS_EN
  logic [31:0]       stat_ins_cnt, stat_qry_cnt, stat_hit_cnt;
  int                st_ins, st_qry, st_hit;
`endif

  always #5 clock = ~clock;

  bf_sram_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_idx0(ins_idx0), .ins_idx1(ins_idx1),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_idx0(qry_idx0), .qry_idx1(qry_idx1),
    .qry_tag(qry_tag), .clr_req(clr_req), .clr_busy(clr_busy),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_tag(rsp_tag),
    .sram_address_a(sram_address_a), .sram_address_b(sram_address_b),
    .sram_data_a(sram_data_a), .sram_data_b(sram_data_b),
    .sram_wren_a(sram_wren_a), .sram_wren_b(sram_wren_b),
    .sram_q_a(sram_q_a), .sram_q_b(sram_q_b)
`ifdef BF_STATS_EN
    , .stat_ins_cnt(stat_ins_cnt), .stat_qry_cnt(stat_qry_cnt), .stat_hit_cnt(stat_hit_cnt)
`endif
  );

  // Dual-port SRAM, 2-cycle read latency, powered up with random contents.
  bit       mem [DEPTH];
  bit       mem_init;
  bit [1:0] pipe_a, pipe_b;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 1'($urandom);
      mem_init <= 1'b1;
    end else begin
      if (sram_wren_a) mem[sram_address_a] <= sram_data_a;
      if (sram_wren_b) mem[sram_address_b] <= sram_data_b;
    end
    pipe_a <= {pipe_a[0], mem[sram_address_a]};
    pipe_b <= {pipe_b[0], mem[sram_address_b]};
  end
  assign sram_q_a = pipe_a[1];
  assign sram_q_b = pipe_b[1];

  typedef struct { logic [TAG_W-1:0] tag; bit hit; int due; } rsp_t;

  int   n_checks, n_errs;
  int   cyc;
  bit   model_bits [DEPTH];
  bit   last_ins, model_busy, pend_clr;
  rsp_t exp_q [$];
  int   rsp_seen;
  int   pend_kind;
  logic [ADDR_W-1:0] pend_a, pend_b;
  int   sw_cnt, sw_err, last_sw_cyc, busy_rdy_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ridx(input int unsigned hi);
    return ADDR_W'($urandom_range(hi, 0));
  endfunction

  // Observe outputs once per cycle, away from the clock edge.
  task automatic sample();
    rsp_t r;
    if (pend_kind == 1) begin
      check("ins_pins", {sram_wren_a, sram_wren_b, sram_data_a, sram_address_a, sram_address_b},
            {1'b1, 1'(pend_a != pend_b), 1'b1, pend_a, pend_b});
      if (pend_a != pend_b) check("ins_data_b", sram_data_b, 1);
    end else if (pend_kind == 2) begin
      check("qry_pins", {sram_wren_a, sram_wren_b, sram_address_a, sram_address_b},
            {2'b00, pend_a, pend_b});
    end
    pend_kind = 0;
    if (pend_clr) begin
      check("clr_busy_set", clr_busy, 1);
      model_busy = 1'b1;
      pend_clr   = 1'b0;
      sw_cnt     = 0;
    end
    if (sram_wren_a && sram_wren_b && !sram_data_a && !sram_data_b) begin
      if (sram_address_a == '0) begin
        sw_cnt = 0;
        check("rsp_drained_before_sweep", exp_q.size(), 0);
      end
      if (!model_busy) sw_err++;
      if (sram_address_a != ADDR_W'(2 * sw_cnt) || sram_address_b != ADDR_W'(2 * sw_cnt + 1)) sw_err++;
      sw_cnt++;
      last_sw_cyc = cyc;
    end
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        r = exp_q.pop_front();
        check("rsp_tag", rsp_tag, r.tag);
        check("rsp_hit", rsp_hit, r.hit);
        check("rsp_latency", cyc, r.due);
`ifdef BF_STATS_EN
        if (r.hit) st_hit++;
`endif
      end
    end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      check("rsp_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    if (model_busy && !clr_busy) begin
      check("sweep_len", sw_cnt, SWEEP_LEN);
      check("sweep_pattern", sw_err, 0);
      check("busy_fall_lag", ((cyc - last_sw_cyc) <= 1), 1);
      check("ready_in_busy", busy_rdy_err, 0);
      model_busy   = 1'b0;
      sw_err       = 0;
      busy_rdy_err = 0;
      foreach (model_bits[i]) model_bits[i] = 1'b0;
`ifdef BF_STATS_EN
      st_ins = 0; st_qry = 0; st_hit = 0;
`endif
    end
  endtask

  // One clock cycle of stimulus; entered and left just after a falling edge.
  task automatic cycle(input bit iv, input logic [ADDR_W-1:0] i0, input logic [ADDR_W-1:0] i1,
                       input bit qv, input logic [ADDR_W-1:0] q0, input logic [ADDR_W-1:0] q1,
                       input logic [TAG_W-1:0] tg, input bit cr);
    bit ia, qa;
    ins_valid = iv; ins_idx0 = i0; ins_idx1 = i1;
    qry_valid = qv; qry_idx0 = q0; qry_idx1 = q1; qry_tag = tg;
    clr_req   = cr;
    #1;
    if (model_busy) begin
      if (ins_ready || qry_ready) busy_rdy_err++;
    end else begin
      check("ins_ready", ins_ready, (!qv || !last_ins));
      check("qry_ready", qry_ready, (!iv || last_ins));
      ia = iv && (!qv || !last_ins);
      qa = qv && (!iv || last_ins);
      if (ia) begin
        model_bits[i0] = 1'b1;
        model_bits[i1] = 1'b1;
        last_ins = 1'b1; pend_kind = 1; pend_a = i0; pend_b = i1;
`ifdef BF_STATS_EN
        st_ins++;
`endif
      end
      if (qa) begin
        exp_q.push_back('{tg, model_bits[q0] & model_bits[q1], cyc + RSP_LAT});
        last_ins = 1'b0; pend_kind = 2; pend_a = q0; pend_b = q1;
`ifdef BF_STATS_EN
        st_qry++;
`endif
      end
      if (cr) pend_clr = 1'b1;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic rand_cycle(input int unsigned hi, input bit cr);
    cycle(1'($urandom), ridx(hi), ridx(hi), 1'($urandom), ridx(hi), ridx(hi), TAG_W'($urandom), cr);
  endtask

  // Random traffic while a clear runs; optional extra clr_req at iteration extra_at.
  task automatic wait_clear(input int budget, input int extra_at);
    for (int i = 0; i < budget && model_busy; i++) rand_cycle(DEPTH - 1, (i == extra_at));
    check("clear_done", model_busy, 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; ins_valid = 1'b1; qry_valid = 1'b1; clr_req = 1'b0;
    #1;
    check("rst_sram", {sram_address_a, sram_address_b, sram_data_a, sram_data_b, sram_wren_a, sram_wren_b}, 0);
    check("rst_ready", {ins_ready, qry_ready}, 0);
    check("rst_rsp", {rsp_valid, rsp_hit, rsp_tag}, 0);
    check("rst_clr_busy", clr_busy, 1);
    exp_q.delete();
    pend_kind = 0; pend_clr = 1'b0; last_ins = 1'b0; model_busy = 1'b1;
    sw_cnt = 0; busy_rdy_err = 0;
`ifdef BF_STATS_EN
    st_ins = 0; st_qry = 0; st_hit = 0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    ins_valid = 1'b0; qry_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    #2 apply_reset();
    wait_clear(SWEEP_LEN + 100, -1);

    // insert then query the same pair one cycle later, then a half-overlapping miss
    cycle(1, 13'h0010, 13'h1FFF, 0, '0, '0, '0, 0);
    cycle(0, '0, '0, 1, 13'h0010, 13'h1FFF, 8'h5A, 0);
    cycle(0, '0, '0, 1, 13'h0010, 13'h0011, 8'h11, 0);
    // equal indices: single-port write
    cycle(1, 13'h0ABC, 13'h0ABC, 0, '0, '0, '0, 0);
    cycle(0, '0, '0, 1, 13'h0ABC, 13'h0ABC, 8'h22, 0);
    idle(6);

    // both classes valid for 6 cycles: alternating grants, three responses
    snap = rsp_seen;
    for (int i = 0; i < 6; i++)
      cycle(1, ridx(DEPTH - 1), ridx(DEPTH - 1), 1, ridx(DEPTH - 1), ridx(DEPTH - 1), TAG_W'(8'h30 + i), 0);
    idle(8);
    check("rr_rsp_count", rsp_seen - snap, 3);

    // clear with two queries in flight, plus an ignored clr_req mid-sweep
    cycle(0, '0, '0, 1, 13'h0010, 13'h1FFF, 8'hA1, 0);
    cycle(0, '0, '0, 1, 13'h0ABC, 13'h0ABC, 8'hA2, 1);
    wait_clear(SWEEP_LEN + 100, 200);
    cycle(0, '0, '0, 1, 13'h0010, 13'h1FFF, 8'hB0, 0);
    idle(6);

    // reset in the middle of a query: its response must never appear
    cycle(0, '0, '0, 1, 13'h0010, 13'h0ABC, 8'hC3, 0);
    idle(1);
    snap = rsp_seen;
    #3 apply_reset();
    wait_clear(SWEEP_LEN + 100, -1);
    idle(8);
    check("rsp_dropped_on_reset", rsp_seen - snap, 0);

    // random traffic over a small index space so hits are common
    for (int i = 0; i < 400; i++) rand_cycle(31, 0);
    idle(8);

`ifdef BF_STATS_EN
    check("stat_ins", stat_ins_cnt, st_ins);
    check("stat_qry", stat_qry_cnt, st_qry);
    check("stat_hit", stat_hit_cnt, st_hit);
`endif
    check("rsp_queue_empty", exp_q.size(), 0);
    check("stray_sweep", sw_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
